// File: rtl/i2s_audio_rx.sv
// I2S master receiver: left channel to Q2.10 samples, queued in a FIFO behind valid/ready.
// Optional I2S_AUDIO_RX_ROUND_EN adds round-half-up. The push is one cycle after the last bit; overrun is sticky when the FIFO is full.
module i2s_audio_rx #(
  parameter int SckDiv    = 4,
  parameter int FifoDepth = 4
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         sd_i,
  output logic         sck_o,
  output logic         ws_o,
  output logic [1:-10] audio_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         overrun_o
);

  localparam int DivW = $clog2(SckDiv);
  localparam int PtrW = $clog2(FifoDepth);
  localparam logic [DivW-1:0] DivLast = DivW'(SckDiv - 1);
  localparam logic [DivW-1:0] CapCnt  = DivW'(2);
  localparam logic [PtrW:0]   PtrOne  = (PtrW + 1)'(1);

  logic [DivW-1:0] div_cnt;
  logic [5:0]      slot;
  logic [5:0]      slot_nxt;
  logic            sd_s1;
  logic            sd_s2;
  logic [23:0]     shreg;
  logic            capture;
  logic            push_pend;
  logic [11:0]     conv;

  logic [11:0]     mem [FifoDepth];
  logic [PtrW:0]   wr_ptr;
  logic [PtrW:0]   rd_ptr;
  logic            empty;
  logic            full;
  logic            pop;
  logic            do_push;

  assign slot_nxt = slot + 6'd1;
  // Left word occupies slots 1..24: the bit after ws falls is the MSB.
  assign capture  = sck_o && (div_cnt == CapCnt) && (slot >= 6'd1) && (slot <= 6'd24);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_cnt   <= '0;
      sck_o     <= 1'b0;
      ws_o      <= 1'b0;
      slot      <= '0;
      sd_s1     <= 1'b0;
      sd_s2     <= 1'b0;
      shreg     <= '0;
      push_pend <= 1'b0;
    end else begin
      sd_s1 <= sd_i;
      sd_s2 <= sd_s1;
      if (div_cnt == DivLast) begin
        div_cnt <= '0;
        sck_o   <= ~sck_o;
        if (sck_o) begin
          slot <= slot_nxt;
          ws_o <= slot_nxt[5];
        end
      end else begin
        div_cnt <= div_cnt + DivW'(1);
      end
      if (capture) begin
        shreg <= {shreg[22:0], sd_s2};
      end
      push_pend <= capture && (slot == 6'd24);
    end
  end

`ifdef I2S_AUDIO_RX_ROUND_EN
  always_comb begin
    conv = shreg[23:12] + {11'd0, shreg[11]};
    // Only the largest positive code can overflow when rounding up.
    if (shreg[23:12] == 12'h7FF && shreg[11]) begin
      conv = 12'h7FF;
    end
  end
`else
  assign conv = shreg[23:12];
`endif

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PtrW] != rd_ptr[PtrW]) && (wr_ptr[PtrW-1:0] == rd_ptr[PtrW-1:0]);
  assign pop     = valid_o && ready_i;
  assign do_push = push_pend && (!full || pop);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overrun_o <= 1'b0;
      for (int i = 0; i < FifoDepth; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[PtrW-1:0]] <= conv;
        wr_ptr                <= wr_ptr + PtrOne;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PtrOne;
      end
      if (push_pend && full && !pop) begin
        overrun_o <= 1'b1;
      end
    end
  end

  assign valid_o = !empty;
  assign audio_o = mem[rd_ptr[PtrW-1:0]];

endmodule

// File: tb/tb_i2s_audio_rx.sv
// Directed bench for i2s_audio_rx: an I2S slave model drives sd_i and a monitor logs accepted samples.
module tb_i2s_audio_rx;
  logic         clk_i   = 1'b0;
  logic         reset_i = 1'b1;
  logic         sd_i    = 1'b1;
  logic         ready_i = 1'b1;
  logic         sck_o;
  logic         ws_o;
  logic         valid_o;
  logic         overrun_o;
  logic [1:-10] audio_o;

  int checks = 0;
  int errors = 0;

  logic [23:0] left_q [$];
  logic [23:0] cur_left   = 24'h0;
  logic [23:0] right_word = 24'hABCDEF;
  int          tx_slot    = 0;
  logic [11:0] rx_q [$];

`ifdef I2S_AUDIO_RX_ROUND_EN
  localparam logic [11:0] ExpNeg   = 12'h000;
  localparam logic [11:0] ExpHalf  = 12'h124;
`else
  localparam logic [11:0] ExpNeg   = 12'hFFF;
  localparam logic [11:0] ExpHalf  = 12'h123;
`endif

  i2s_audio_rx dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .sd_i     (sd_i),
    .sck_o    (sck_o),
    .ws_o     (ws_o),
    .audio_o  (audio_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .overrun_o(overrun_o)
  );

  always #5 clk_i = ~clk_i;

  // Slave transmitter: new bit after each falling sck, MSB one slot after ws changes.
  always @(negedge sck_o or posedge reset_i) begin
    #1;
    if (reset_i) begin
      tx_slot = 0;
      sd_i    = 1'b1;
    end else begin
      tx_slot = (tx_slot + 1) % 64;
      if (tx_slot == 1 && left_q.size() > 0) cur_left = left_q.pop_front();
      if (tx_slot >= 1 && tx_slot <= 24) sd_i = cur_left[24 - tx_slot];
      else if (tx_slot >= 33 && tx_slot <= 56) sd_i = right_word[56 - tx_slot];
      else sd_i = 1'b1;
    end
  end

  always @(negedge clk_i) begin
    if (!reset_i && valid_o && ready_i) rx_q.push_back(audio_o);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    tick(10);
    checks++; if (sck_o !== 1'b0) begin errors++; $display("FAIL reset_sck got %b want 0", sck_o); end
    checks++; if (ws_o !== 1'b0) begin errors++; $display("FAIL reset_ws got %b want 0", ws_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid_o); end
    checks++; if (audio_o !== 12'h000) begin errors++; $display("FAIL reset_audio got %h want 000", audio_o); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun_o); end
    reset_i = 1'b0;
    tick(3);
    checks++; if (sck_o !== 1'b0) begin errors++; $display("FAIL sck_c3 got %b want 0", sck_o); end
    tick(1);
    checks++; if (sck_o !== 1'b1) begin errors++; $display("FAIL sck_c4 got %b want 1", sck_o); end
    tick(4);
    checks++; if (sck_o !== 1'b0) begin errors++; $display("FAIL sck_c8 got %b want 0", sck_o); end
    tick(182);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL valid_c190 got %b want 0", valid_o); end
    tick(65);
    checks++; if (ws_o !== 1'b0) begin errors++; $display("FAIL ws_c255 got %b want 0", ws_o); end
    tick(1);
    checks++; if (ws_o !== 1'b1) begin errors++; $display("FAIL ws_c256 got %b want 1", ws_o); end
    tick(255);
    checks++; if (ws_o !== 1'b1) begin errors++; $display("FAIL ws_c511 got %b want 1", ws_o); end
    tick(1);
    checks++; if (ws_o !== 1'b0) begin errors++; $display("FAIL ws_c512 got %b want 0", ws_o); end
  endtask

  task automatic test_basic();
    int base;
    base = rx_q.size();
    for (int i = 0; i < 3; i++) left_q.push_back(24'h400000);
    tick(200);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid_rise got %b want 1", valid_o); end
    checks++; if (audio_o !== 12'h400) begin errors++; $display("FAIL basic_head got %h want 400", audio_o); end
    tick(1);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL basic_valid_fall got %b want 0", valid_o); end
    tick(1335);
    checks++; if (rx_q.size() - base !== 3) begin errors++; $display("FAIL basic_count got %0d want 3", rx_q.size() - base); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rx_q[base + i] !== 12'h400) begin errors++; $display("FAIL basic_sample%0d got %h want 400", i, rx_q[base + i]); end
    end
  endtask

  task automatic test_convert();
    int base;
    logic [11:0] exp_v [3];
    exp_v[0] = ExpNeg; exp_v[1] = 12'h7FF; exp_v[2] = ExpHalf;
    base = rx_q.size();
    left_q.push_back(24'hFFF800);
    left_q.push_back(24'h7FF800);
    left_q.push_back(24'h123C00);
    tick(1536);
    checks++; if (rx_q.size() - base !== 3) begin errors++; $display("FAIL conv_count got %0d want 3", rx_q.size() - base); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (rx_q[base + i] !== exp_v[i]) begin errors++; $display("FAIL conv_sample%0d got %h want %h", i, rx_q[base + i], exp_v[i]); end
    end
  endtask

  task automatic test_overrun();
    int base;
    ready_i = 1'b0;
    base = rx_q.size();
    for (int i = 1; i <= 5; i++) left_q.push_back(24'(i) << 12);
    tick(1737);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL ovr_valid4 got %b want 1", valid_o); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL ovr_clear4 got %b want 0", overrun_o); end
    tick(512);
    checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_set5 got %b want 1", overrun_o); end
    ready_i = 1'b1;
    tick(4);
    ready_i = 1'b0;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL ovr_drained got %b want 0", valid_o); end
    checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", overrun_o); end
    checks++; if (rx_q.size() - base !== 4) begin errors++; $display("FAIL ovr_count got %0d want 4", rx_q.size() - base); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rx_q[base + i] !== 12'(i + 1)) begin errors++; $display("FAIL ovr_sample%0d got %h want %h", i, rx_q[base + i], 12'(i + 1)); end
    end
  endtask

  task automatic test_mid_reset();
    tick(900);
    left_q.push_back(24'h5A5000);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b want 1", valid_o); end
    reset_i = 1'b1;
    tick(1);
    checks++; if (sck_o !== 1'b0) begin errors++; $display("FAIL mid_sck got %b want 0", sck_o); end
    checks++; if (ws_o !== 1'b0) begin errors++; $display("FAIL mid_ws got %b want 0", ws_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", valid_o); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL mid_overrun got %b want 0", overrun_o); end
    checks++; if (audio_o !== 12'h000) begin errors++; $display("FAIL mid_audio got %h want 000", audio_o); end
    reset_i = 1'b0;
    ready_i = 1'b1;
    tick(200);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL mid_frame_valid got %b want 1", valid_o); end
    checks++; if (audio_o !== 12'h5A5) begin errors++; $display("FAIL mid_frame_audio got %h want 5a5", audio_o); end
    tick(1);
  endtask

  task automatic test_full_pushpop();
    int base;
    logic [11:0] exp_v [5];
    exp_v[0] = 12'h111; exp_v[1] = 12'h222; exp_v[2] = 12'h333; exp_v[3] = 12'h444; exp_v[4] = 12'h555;
    ready_i = 1'b0;
    base = rx_q.size();
    for (int i = 0; i < 5; i++) left_q.push_back({exp_v[i], 12'h000});
    tick(2558);
    ready_i = 1'b1;
    tick(1);
    ready_i = 1'b0;
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL pp_overrun got %b want 0", overrun_o); end
    checks++; if (audio_o !== 12'h222) begin errors++; $display("FAIL pp_head got %h want 222", audio_o); end
    ready_i = 1'b1;
    tick(3);
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL pp_occ4 got %b want 1", valid_o); end
    tick(1);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL pp_empty got %b want 0", valid_o); end
    checks++; if (rx_q.size() - base !== 5) begin errors++; $display("FAIL pp_count got %0d want 5", rx_q.size() - base); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (rx_q[base + i] !== exp_v[i]) begin errors++; $display("FAIL pp_sample%0d got %h want %h", i, rx_q[base + i], exp_v[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_convert();
    test_overrun();
    test_mid_reset();
    test_full_pushpop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2s_audio_rx.md
# i2s_audio_rx

I2S master receiver that produces the tuner's audio sample stream. It generates the serial bit clock and word select for an external I2S microphone/ADC and deserializes the left channel. Each 24-bit sample is reduced to signed Q2.10 and buffered in a small FIFO. The FIFO output drives the tuner's audio input through a valid/ready handshake.

## Interface
Parameters:
- SckDiv, 4: clk_i cycles per sck_o half-period; minimum legal value is 4.
- FifoDepth, 4: sample FIFO entries; must be a power of two, ≥2.

Ports:
- clk_i  input  1  system clock; one clock domain.
- reset_i  input  1  synchronous, active-high reset.
- sd_i  input  1  I2S serial data from device; asynchronous to clk_i.
- sck_o  output  1  I2S bit clock; period 2*SckDiv clk_i cycles.
- ws_o  output  1  I2S word select; 0 = left, 1 = right.
- audio_o  output  [1:-10]  signed sample, Q2.10.
- valid_o  output  1  audio_o holds a sample.
- ready_i  input  1  consumer accepts the sample.
- overrun_o  output  1  sticky flag: a sample was dropped because the FIFO was full.

## Operation
- **Divider:** counts 0..SckDiv-1. On terminal count it toggles sck_o and restarts.
- **Slot:** one full sck_o period, beginning at a falling edge (low phase first). Frame = slots 0..63.
- **Word select:** ws_o=0 for slots 0..31 and 1 for slots 32..63. ws_o changes only at slot start (falling edge).
- **Synchronizer:** sd_i passes through a 2-flop synchronizer.
- **Bit capture:** one bit per slot, taken from the synchronized sd. Capture occurs in the high phase, on the cycle where the divider count == 2.
- **Left word:** slots 1..24 are captured MSB first into a 24-bit shift register (standard I2S one-slot delay after ws). Slot 0 and slots 25..63 are ignored; the right channel is discarded.
- **Conversion:** after the slot-24 capture, the 24-bit word s is converted and pushed into the FIFO.
  - Truncation: audio = s[23:12].
- **FIFO:** circular buffer, FifoDepth entries.
  - Read and write pointers wrap modulo FifoDepth; full/empty come from an extra pointer bit.
  - Push when full: sample dropped, contents unchanged, overrun_o set to 1. overrun_o clears only on reset.
  - Push and pop in the same cycle: both occur, including when full, so no overrun.
- **Handshake:** transfer occurs on any cycle where valid_o && ready_i.
  - valid_o = FIFO not empty.
  - audio_o = head entry; stable while valid_o && !ready_i.
  - Sample order is preserved.
- **Reset** (at any point, including mid-frame): sck_o=0, ws_o=0, divider=0, slot=0, shift register cleared, FIFO emptied. Outputs: valid_o=0, audio_o=0, overrun_o=0. The first frame after reset is captured normally.

## Timing
- sck_o first rises SckDiv cycles after reset deasserts. A frame is 128*SckDiv cycles (512 at the default).
- Push occurs on the cycle after the slot-24 capture. valid_o rises on the cycle after the push (the FIFO is registered).
- Pop takes effect at the clock edge. The next entry, or valid_o=0, appears the following cycle.
- Maximum sustained consumer rate needed: one sample per frame.

## Configuration
- **I2S_AUDIO_RX_ROUND_EN**
  - Defined: round half up, audio = s[23:12] + s[11]. If s[23:12]==0x7FF and s[11]==1, the result saturates to 0x7FF. No other saturation is needed.
  - Undefined: plain truncation, audio = s[23:12]. The rounding adder is absent.

## Test plan
- Reset for 10 cycles, then idle → sck_o toggles every 4 cycles; ws_o rises at cycle 256 of the frame and falls at 512; valid_o stays 0 until the first push.
- Bench I2S model drives left word 0x400000 (right 0xABCDEF), ready_i=1 → exactly one sample per frame, audio_o=0x400; right data never appears.
- Left word 0xFFF800 → audio_o=0xFFF without the macro, 0x000 with it. Left word 0x7FF800 with the macro → 0x7FF (saturated).
- ready_i=0 for 5 frames carrying left words 1..5 (<<12) → after frame 4, valid_o=1 and no overrun. After frame 5, overrun_o=1. Then ready_i=1 → outputs 1,2,3,4 in order, then valid_o=0. overrun_o stays 1.
- Push and pop in the same cycle while the FIFO is full → no overrun; FIFO occupancy stays at 4.
- reset_i pulsed during slot 10 → next cycle sck_o=0, ws_o=0, valid_o=0, overrun_o=0. The following full frame delivers its left word correctly.
